// File: rtl/load_store_unit_if.sv
// Request/response handshake to the core plus the RAM port-B data bus, bundled for the LSU.
// The slave modport is the LSU view. The master modport is the core/RAM side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_fault;

  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_isRequest;
  logic [31:0] mem_dout;
  logic        mem_requestDone;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_dout, mem_requestDone,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_fault,
    output mem_we, mem_addr, mem_din, mem_isRequest
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output mem_dout, mem_requestDone,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_fault,
    input  mem_we, mem_addr, mem_din, mem_isRequest
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I data-side load/store unit: legality/alignment check, RAM port-B request with byte
// enables and replicated store data, load extraction/extension, and a request timeout.
module load_store_unit #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  a_q, a_d;
  logic [2:0]  f3_q, f3_d;
  logic        store_q, store_d;
  logic [4:0]  rd_q, rd_d;
  logic [15:0] cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [1:0]  resp_fault_q, resp_fault_d;
  logic        mem_req_q, mem_req_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;

  logic        accept, illegal, misaligned, timeout;
  logic [3:0]  lane_we;
  logic [31:0] lane_din, load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign bus.req_ready = (state_q == StIdle) & ~rst;
  assign accept = bus.req_valid & bus.req_ready;
  assign timeout = (cnt_q == TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    if (bus.req_is_store) begin
      illegal = bus.req_funct3[2] | (bus.req_funct3 == 3'b011);
    end else begin
      illegal = (bus.req_funct3 == 3'b011) | (bus.req_funct3 == 3'b110) |
                (bus.req_funct3 == 3'b111);
    end
    misaligned = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                 ((bus.req_funct3[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00));
  end

  always_comb begin
    lane_we  = 4'h0;
    lane_din = 32'h0;
    if (bus.req_is_store) begin
      case (bus.req_funct3[1:0])
        2'b00: begin
          lane_we  = 4'b0001 << bus.req_addr[1:0];
          lane_din = {4{bus.req_wdata[7:0]}};
        end
        2'b01: begin
          lane_we  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
          lane_din = {2{bus.req_wdata[15:0]}};
        end
        default: begin
          lane_we  = 4'hF;
          lane_din = bus.req_wdata;
        end
      endcase
    end
  end

  // Lane selection uses the offset registered at accept, not the live request address.
  always_comb begin
    byte_sel = bus.mem_dout[{a_q, 3'b000} +: 8];
    half_sel = a_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = bus.mem_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (illegal | misaligned) ? StResp : StReq;
      StReq:  if (bus.mem_requestDone | timeout) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d          = a_q;
    f3_d         = f3_q;
    store_d      = store_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    resp_fault_d = resp_fault_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rd_d = bus.req_rd;
          if (illegal | misaligned) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
            resp_rd_d    = bus.req_rd;
            resp_fault_d = illegal ? 2'b11 : 2'b01;
          end else begin
            a_d        = bus.req_addr[1:0];
            f3_d       = bus.req_funct3;
            store_d    = bus.req_is_store;
            cnt_d      = 16'h0;
            mem_req_d  = 1'b1;
            mem_we_d   = lane_we;
            mem_din_d  = lane_din;
            mem_addr_d = {bus.req_addr[31:2], 2'b00};
          end
        end
      end
      StReq: begin
        if (bus.mem_requestDone) begin
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = store_q ? 32'h0 : load_data;
          resp_rd_d    = rd_q;
          resp_fault_d = 2'b00;
        end else if (timeout) begin
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'h0;
          resp_rd_d    = rd_q;
          resp_fault_d = 2'b10;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= 2'b00;
      f3_q         <= 3'b000;
      store_q      <= 1'b0;
      rd_q         <= 5'd0;
      cnt_q        <= 16'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_rd_q    <= 5'd0;
      resp_fault_q <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 4'h0;
      mem_addr_q   <= 32'h0;
      mem_din_q    <= 32'h0;
    end else begin
      a_q          <= a_d;
      f3_q         <= f3_d;
      store_q      <= store_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      resp_fault_q <= resp_fault_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
    end
  end

  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_rd       = resp_rd_q;
  assign bus.resp_fault    = resp_fault_q;
  assign bus.mem_isRequest = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_din       = mem_din_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: drives core requests, plays the RAM, and scores responses
// against expectations queued at request time.
module tb_load_store_unit;
  logic clk;
  logic rst;
  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_rd", {27'd0, bus.resp_rd}, {27'd0, e.rd});
        check("resp_fault", {30'd0, bus.resp_fault}, {30'd0, e.fault});
      end
    end
  end

  // lat = cycles isRequest is high including the cycle done is sampled.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input int lat,
                        input logic [31:0] dout, input logic [31:0] exp_rdata,
                        input logic [1:0] exp_fault, input logic [3:0] exp_we,
                        input logic [31:0] exp_din);
    exp_t e;
    @(negedge clk);
    check("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
    e.rdata = exp_rdata;
    e.rd    = rd;
    e.fault = exp_fault;
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (exp_fault == 2'b01 || exp_fault == 2'b11) begin
      check("fault_no_req", {31'd0, bus.mem_isRequest}, 32'd0);
      check("fault_pulse", {31'd0, bus.resp_valid}, 32'd1);
      @(negedge clk);
      check("fault_ready", {31'd0, bus.req_ready}, 32'd1);
    end else begin
      check("req_high", {31'd0, bus.mem_isRequest}, 32'd1);
      check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
      check("mem_we", {28'd0, bus.mem_we}, {28'd0, exp_we});
      check("mem_din", bus.mem_din, exp_din);
      if (exp_fault == 2'b10) begin
        int cyc = 0;
        while (bus.mem_isRequest === 1'b1 && cyc < 40) begin
          cyc++;
          @(negedge clk);
        end
        check("timeout_len", cyc, 32'd8);
        check("timeout_pulse", {31'd0, bus.resp_valid}, 32'd1);
      end else begin
        repeat (lat - 1) begin
          @(negedge clk);
          check("req_held", {31'd0, bus.mem_isRequest}, 32'd1);
          check("we_held", {28'd0, bus.mem_we}, {28'd0, exp_we});
        end
        bus.mem_requestDone = 1'b1;
        bus.mem_dout        = dout;
        @(negedge clk);
        bus.mem_requestDone = 1'b0;
        bus.mem_dout        = 32'hFFFF_FFFF;
        check("done_pulse", {31'd0, bus.resp_valid}, 32'd1);
        check("req_dropped", {31'd0, bus.mem_isRequest}, 32'd0);
      end
      @(negedge clk);
      check("ready_back", {31'd0, bus.req_ready}, 32'd1);
      check("pulse_one", {31'd0, bus.resp_valid}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid       = 1'b0;
    bus.req_is_store    = 1'b0;
    bus.req_funct3      = 3'b000;
    bus.req_addr        = 32'h0;
    bus.req_wdata       = 32'h0;
    bus.req_rd          = 5'd0;
    bus.mem_dout        = 32'hFFFF_FFFF;
    bus.mem_requestDone = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_rd", {27'd0, bus.resp_rd}, 32'd0);
    check("rst_fault", {30'd0, bus.resp_fault}, 32'd0);
    check("rst_isreq", {31'd0, bus.mem_isRequest}, 32'd0);
    check("rst_we", {28'd0, bus.mem_we}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_din", bus.mem_din, 32'd0);
    rst = 1'b0;

    // Stores
    access(1'b1, 3'b010, 32'h8000_0000, 32'hDEAD_BEEF, 5'd1, 3, 32'h0, 32'h0, 2'b00,
           4'hF, 32'hDEAD_BEEF);
    access(1'b1, 3'b000, 32'h8000_0003, 32'h1234_56AB, 5'd2, 1, 32'h0, 32'h0, 2'b00,
           4'b1000, 32'hABAB_ABAB);
    access(1'b1, 3'b001, 32'h8000_0002, 32'h5555_CAFE, 5'd3, 2, 32'h0, 32'h0, 2'b00,
           4'b1100, 32'hCAFE_CAFE);
    // Loads
    access(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd4, 2, 32'hAB00_0000, 32'hFFFF_FFAB, 2'b00,
           4'h0, 32'h0);
    access(1'b0, 3'b100, 32'h8000_0003, 32'h0, 5'd5, 1, 32'hAB00_0000, 32'h0000_00AB, 2'b00,
           4'h0, 32'h0);
    access(1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd6, 3, 32'h8001_0000, 32'hFFFF_8001, 2'b00,
           4'h0, 32'h0);
    access(1'b0, 3'b101, 32'h8000_0002, 32'h0, 5'd7, 1, 32'h8001_0000, 32'h0000_8001, 2'b00,
           4'h0, 32'h0);
    access(1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd8, 2, 32'h1234_5678, 32'h1234_5678, 2'b00,
           4'h0, 32'h0);
    access(1'b0, 3'b000, 32'h8000_0001, 32'h0, 5'd9, 1, 32'h0000_7F00, 32'h0000_007F, 2'b00,
           4'h0, 32'h0);
    access(1'b0, 3'b001, 32'h8000_0000, 32'h0, 5'd10, 1, 32'hBEEF_8123, 32'hFFFF_8123, 2'b00,
           4'h0, 32'h0);
    // Faults at accept
    access(1'b0, 3'b001, 32'h8000_0001, 32'h0, 5'd11, 1, 32'h0, 32'h0, 2'b01, 4'h0, 32'h0);
    access(1'b0, 3'b011, 32'h8000_0000, 32'h0, 5'd12, 1, 32'h0, 32'h0, 2'b11, 4'h0, 32'h0);
    access(1'b1, 3'b100, 32'h8000_0000, 32'h0, 5'd13, 1, 32'h0, 32'h0, 2'b11, 4'h0, 32'h0);
    access(1'b1, 3'b010, 32'h8000_0002, 32'h0, 5'd14, 1, 32'h0, 32'h0, 2'b01, 4'h0, 32'h0);
    access(1'b0, 3'b110, 32'h8000_0003, 32'h0, 5'd15, 1, 32'h0, 32'h0, 2'b11, 4'h0, 32'h0);
    // Timeout
    access(1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd21, 1, 32'h0, 32'h0, 2'b10, 4'h0, 32'h0);
    // Done on the final allowed wait cycle still wins over timeout
    access(1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd22, 8, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 2'b00,
           4'h0, 32'h0);

    // Reset while in REQ: no response, late done ignored
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h8000_0010;
    bus.req_wdata    = 32'h0BAD_F00D;
    bus.req_rd       = 5'd23;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_test_req", {31'd0, bus.mem_isRequest}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_isreq", {31'd0, bus.mem_isRequest}, 32'd0);
    check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_mid_valid", {31'd0, bus.resp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.mem_requestDone = 1'b1;
    bus.mem_dout        = 32'h1111_2222;
    @(negedge clk);
    bus.mem_requestDone = 1'b0;
    check("late_done_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("late_done_isreq", {31'd0, bus.mem_isRequest}, 32'd0);
    access(1'b1, 3'b010, 32'h8000_0000, 32'hCAFE_BABE, 5'd24, 2, 32'h0, 32'h0, 2'b00,
           4'hF, 32'hCAFE_BABE);

    repeat (3) @(negedge clk);
    check("sb_drain", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side load/store unit between the core's memory stage and the RAM interface data port (port B: `weB`/`addrB`/`dinB`/`isRequestB`/`doutB`/`requestDoneB`). It accepts one RV32I load or store per handshake and checks alignment and funct3 legality. Legal accesses become a word-aligned RAM request with byte enables and lane-replicated store data. Load data is returned byte/half-extracted and sign- or zero-extended, and a missing `requestDone` is reported as a timeout fault.

## Interface

- `TIMEOUT_CYCLES`, 16'd255: consecutive wait-cycles in REQ without `requestDone` before a timeout fault; legal 1..65535.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  request accepted at an edge when `req_valid & req_ready`.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_rd`  in  5  destination tag, passed through to the response.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_rd`  out  5  tag of the completed request.
- `resp_fault`  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
- `mem_we`  out  4  byte write enables to `weB`.
- `mem_addr`  out  32  word-aligned address to `addrB` (`[1:0]`=00).
- `mem_din`  out  32  lane-replicated store data to `dinB`.
- `mem_isRequest`  out  1  to `isRequestB`.
- `mem_dout`  in  32  from `doutB`; valid in the cycle `requestDone` is high.
- `mem_requestDone`  in  1  from `requestDoneB`.

## Operation

- States: IDLE, REQ, RESP. `req_ready = (state==IDLE) & ~rst`.
- IDLE, accept, legal and aligned:
  - Register `addr[1:0]`, funct3, store flag and rd.
  - Set `mem_addr={addr[31:2],2'b00}`, `mem_isRequest<=1`, clear the timeout counter, go to REQ.
- IDLE, accept, illegal or misaligned: no RAM access. Go to RESP with the fault code and `resp_rdata=0`.
- Illegal: load funct3 011/110/111; store funct3 with bit2=1 or 011.
- Misaligned: half access with `addr[0]=1`; word access with `addr[1:0]!=0`. Illegal takes priority over misaligned.
- Store lanes:
  - SB: `mem_din={4{wdata[7:0]}}`, `mem_we=4'b0001<<addr[1:0]`.
  - SH: `mem_din={2{wdata[15:0]}}`, `mem_we=addr[1]?4'b1100:4'b0011`.
  - SW: `mem_din=wdata`, `mem_we=4'hF`.
  - Loads: `mem_we=4'h0`; `mem_din` don't-care, driven 0.
- REQ:
  - `mem_isRequest` and all `mem_*` outputs are held stable.
  - Edge with `mem_requestDone=1`: capture and extract `mem_dout`, drop `mem_isRequest`, `resp_fault=00`, go to RESP.
  - Load extraction uses the registered `addr[1:0]` to select byte `dout[8*a+:8]` or half `dout[16*a[1]+:16]`. LB/LH sign-extend; LBU/LHU zero-extend.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT_CYCLES-1` with no done: drop `mem_isRequest`, `resp_fault=10`, go to RESP.
  - Done wins over timeout on the same edge.
- RESP: `resp_valid=1` for exactly one cycle; next edge returns to IDLE.
- `mem_requestDone` outside REQ is ignored.
- `rst`: next edge forces IDLE. No response is produced for an in-flight request.

## Timing

- All outputs registered except `req_ready`.
- Reset values: `resp_valid=0`, `resp_rdata=0`, `resp_rd=0`, `resp_fault=00`, `mem_isRequest=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`, `req_ready=0` while `rst` is high.
- Accept at edge N: `mem_isRequest` is high from cycle N+1.
- Done sampled at edge M (M≥N+1): `resp_valid` is high during cycle M+1; `req_ready` returns at edge M+2.
- Fault-at-accept: `resp_valid` is high in cycle N+1; no `mem_isRequest` pulse.
- `mem_isRequest` is always low for ≥1 cycle between requests.
- Max throughput: one access per RAM latency + 2 cycles.

## Test plan

- SW `0xDEADBEEF` to `0x8000_0000`:
  - `mem_we=F`, `mem_addr=0x8000_0000`, `mem_din=0xDEADBEEF`.
  - `isRequest` is held until done; then `resp_valid` pulses one cycle, fault 00, rdata 0.
- SB `0x...AB` to `0x8000_0003`: `mem_we=4'b1000`, `mem_din=0xABABABAB`, `mem_addr=0x8000_0000`.
- LB and LBU at `0x8000_0003` with `mem_dout=0xAB00_0000`: responses `0xFFFF_FFAB` and `0x0000_00AB`. LH at `0x8000_0002` with `0x8001_0000` gives `0xFFFF_8001`.
- LH `0x8000_0001`: no `isRequest`, `resp_fault=01` next cycle. Load funct3=011: `resp_fault=11`.
- `TIMEOUT_CYCLES=8`, `requestDone` never asserted: `isRequest` is high for 8 cycles, then drops; `resp_fault=10`, `resp_rd` equals the request tag.
- `rst` asserted in REQ: next cycle `isRequest=0`, state IDLE, no `resp_valid`. A late `requestDone` is ignored, and the next SW completes normally.
